// File: rtl/feature_fetch_if.sv
// Bus bundle between feature_fetch and its surroundings: the two point-RAM read
// ports plus the outgoing point stream with valid/ready handshake.
interface feature_fetch_if #(
    parameter int AW = 8,
    parameter int DW = 24
);
    logic [AW-1:0] left_rdaddr;
    logic          left_rden;
    logic [DW-1:0] left_axis;
    logic [AW-1:0] right_rdaddr;
    logic          right_rden;
    logic [DW-1:0] right_axis;
    logic [11:0]   pt_x;
    logic [11:0]   pt_y;
    logic          pt_side;
    logic          pt_vld;
    logic          pt_rdy;

    modport master (
        output left_rdaddr, left_rden,
        input  left_axis,
        output right_rdaddr, right_rden,
        input  right_axis,
        output pt_x, pt_y, pt_side, pt_vld,
        input  pt_rdy
    );

    modport slave (
        input  left_rdaddr, left_rden,
        output left_axis,
        input  right_rdaddr, right_rden,
        output right_axis,
        input  pt_x, pt_y, pt_side, pt_vld,
        output pt_rdy
    );
endinterface

// File: rtl/feature_fetch.sv
// Reads back the left then right feature-point RAMs after each frame and streams
// the points out through a 2-entry skid FIFO that absorbs the 1-clk RAM latency.
module feature_fetch #(
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_done,
    input  logic [AW:0]   left_cnt,
    input  logic [AW:0]   right_cnt,
    feature_fetch_if.master bus,
    output logic          busy,
    output logic          fetch_done,
    output logic          frame_drop
);
    typedef enum logic [2:0] {IDLE, LEFT, RIGHT, DRAIN, DONE} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_t      state_q, state_d;
    logic [AW:0] lcnt_q, lcnt_d;
    logic [AW:0] rcnt_q, rcnt_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        inflight_q, inflight_d;
    logic        inflight_side_q, inflight_side_d;
    logic        fetch_done_q, fetch_done_d;
    logic        frame_drop_q, frame_drop_d;

    logic [1:0][DW-1:0] fifo_data_q, fifo_data_d;
    logic [1:0]         fifo_side_q, fifo_side_d;
    logic               fifo_wr_q, fifo_wr_d;
    logic               fifo_rd_q, fifo_rd_d;
    logic [1:0]         fifo_cnt_q, fifo_cnt_d;

    logic          push;
    logic          pop;
    logic [2:0]    occ;
    logic          can_issue;
    logic [DW-1:0] in_word;
    logic [DW-1:0] head_word;

    assign push      = inflight_q;
    assign pop       = (fifo_cnt_q != 2'd0) && bus.pt_rdy;
    // Committed slots = stored + in flight, minus the one leaving this cycle.
    assign occ       = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign can_issue = (occ < 3'd2);
    assign in_word   = inflight_side_q ? bus.right_axis : bus.left_axis;
    assign head_word = fifo_data_q[fifo_rd_q];

    always_comb begin
        state_d         = state_q;
        lcnt_d          = lcnt_q;
        rcnt_d          = rcnt_q;
        rd_ptr_d        = rd_ptr_q;
        inflight_d      = 1'b0;
        inflight_side_d = inflight_side_q;
        bus.left_rden   = 1'b0;
        bus.right_rden  = 1'b0;
        fetch_done_d    = (state_q == DONE);
        frame_drop_d    = frame_done && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (frame_done) begin
                    lcnt_d   = (left_cnt  > DEPTH_C) ? DEPTH_C : left_cnt;
                    rcnt_d   = (right_cnt > DEPTH_C) ? DEPTH_C : right_cnt;
                    rd_ptr_d = '0;
                    if (lcnt_d != '0)      state_d = LEFT;
                    else if (rcnt_d != '0) state_d = RIGHT;
                    else                   state_d = DONE;
                end
            end
            LEFT: begin
                if (can_issue) begin
                    bus.left_rden   = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_side_d = 1'b0;
                    if (rd_ptr_q == lcnt_q - ONE_C) begin
                        rd_ptr_d = '0;
                        state_d  = (rcnt_q != '0) ? RIGHT : DRAIN;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ONE_C;
                    end
                end
            end
            RIGHT: begin
                if (can_issue) begin
                    bus.right_rden  = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_side_d = 1'b1;
                    if (rd_ptr_q == rcnt_q - ONE_C) begin
                        rd_ptr_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ONE_C;
                    end
                end
            end
            DRAIN: begin
                if ((fifo_cnt_q == 2'd0) && !inflight_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_side_d = fifo_side_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_rd_d   = fifo_rd_q;
        if (push) begin
            fifo_data_d[fifo_wr_q] = in_word;
            fifo_side_d[fifo_wr_q] = inflight_side_q;
            fifo_wr_d              = ~fifo_wr_q;
        end
        if (pop) fifo_rd_d = ~fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            lcnt_q          <= '0;
            rcnt_q          <= '0;
            rd_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_side_q <= 1'b0;
            fetch_done_q    <= 1'b0;
            frame_drop_q    <= 1'b0;
            fifo_data_q     <= '0;
            fifo_side_q     <= '0;
            fifo_wr_q       <= 1'b0;
            fifo_rd_q       <= 1'b0;
            fifo_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            lcnt_q          <= lcnt_d;
            rcnt_q          <= rcnt_d;
            rd_ptr_q        <= rd_ptr_d;
            inflight_q      <= inflight_d;
            inflight_side_q <= inflight_side_d;
            fetch_done_q    <= fetch_done_d;
            frame_drop_q    <= frame_drop_d;
            fifo_data_q     <= fifo_data_d;
            fifo_side_q     <= fifo_side_d;
            fifo_wr_q       <= fifo_wr_d;
            fifo_rd_q       <= fifo_rd_d;
            fifo_cnt_q      <= fifo_cnt_d;
        end
    end

    // Address is presented unconditionally; only rden qualifies it.
    assign bus.left_rdaddr  = rd_ptr_q[AW-1:0];
    assign bus.right_rdaddr = rd_ptr_q[AW-1:0];
    assign bus.pt_vld       = (fifo_cnt_q != 2'd0);
    assign bus.pt_x         = head_word[23:12];
    assign bus.pt_y         = head_word[11:0];
    assign bus.pt_side      = fifo_side_q[fifo_rd_q];
    assign busy             = (state_q != IDLE);
    assign fetch_done       = fetch_done_q;
    assign frame_drop       = frame_drop_q;
endmodule

// File: tb/tb_feature_fetch.sv
// Directed bench for feature_fetch: RAM model, stream monitor, and a linear
// sequence of frames covering basic, backpressure, empty, saturation, overrun, reset.
module tb_feature_fetch;
    logic       clk;
    logic       rst_n;
    logic       frame_done;
    logic [8:0] left_cnt;
    logic [8:0] right_cnt;
    logic       busy;
    logic       fetch_done;
    logic       frame_drop;

    feature_fetch_if #(.AW(8), .DW(24)) bus ();

    feature_fetch #(.AW(8), .DEPTH(256), .DW(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_done (frame_done),
        .left_cnt   (left_cnt),
        .right_cnt  (right_cnt),
        .bus        (bus),
        .busy       (busy),
        .fetch_done (fetch_done),
        .frame_drop (frame_drop)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [24:0] pts[$];
    int          acc_cyc[$];
    int          laddr[$];
    int          raddr[$];
    int          fd_cnt, fd_cyc, drop_cnt, drop_cyc, viol;
    int          issued, accepted;
    logic        prev_stall;
    logic [24:0] prev_data;
    int          f_cyc, d_cyc;

    logic rdy_mode  = 1'b0;
    logic rdy_const = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // RAM model: left[i] = {i+1, 100}, right[i] = {400+i, 200}
    initial begin
        bus.left_axis  = '0;
        bus.right_axis = '0;
        forever begin
            @(posedge clk);
            if (bus.left_rden)
                bus.left_axis <= {12'(int'(bus.left_rdaddr) + 1), 12'd100};
            if (bus.right_rden)
                bus.right_axis <= {12'(int'(bus.right_rdaddr) + 400), 12'd200};
        end
    end

    initial begin
        int ph;
        ph = 0;
        bus.pt_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) bus.pt_rdy = (ph % 4 == 0) || (ph % 4 == 3);
            else          bus.pt_rdy = rdy_const;
            ph = ph + 1;
        end
    end

    // Monitor: records traffic and counts protocol violations
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            issued     = 0;
            accepted   = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus.left_rden && bus.right_rden) viol = viol + 1;
            if (!busy && (bus.left_rden || bus.right_rden)) viol = viol + 1;
            if (issued - accepted > 2) viol = viol + 1;
            if (prev_stall && (!bus.pt_vld || {bus.pt_side, bus.pt_x, bus.pt_y} != prev_data))
                viol = viol + 1;
            prev_stall = bus.pt_vld && !bus.pt_rdy;
            prev_data  = {bus.pt_side, bus.pt_x, bus.pt_y};
            if (bus.pt_vld && bus.pt_rdy) begin
                pts.push_back({bus.pt_side, bus.pt_x, bus.pt_y});
                acc_cyc.push_back(cyc);
                accepted = accepted + 1;
            end
            if (bus.left_rden) begin
                laddr.push_back(int'(bus.left_rdaddr));
                issued = issued + 1;
            end
            if (bus.right_rden) begin
                raddr.push_back(int'(bus.right_rdaddr));
                issued = issued + 1;
            end
            if (fetch_done) begin
                fd_cnt = fd_cnt + 1;
                fd_cyc = cyc;
            end
            if (frame_drop) begin
                drop_cnt = drop_cnt + 1;
                drop_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_mon();
        pts.delete();
        acc_cyc.delete();
        laddr.delete();
        raddr.delete();
        fd_cnt   = 0;
        fd_cyc   = 0;
        drop_cnt = 0;
        drop_cyc = 0;
        viol     = 0;
    endtask

    task automatic frame(input int lc, input int rc);
        left_cnt   = 9'(lc);
        right_cnt  = 9'(rc);
        frame_done = 1'b1;
        f_cyc      = cyc;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((fd_cnt == 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        chk(tag, 32'(n < budget), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] exp_pt(input int i, input int lc);
        if (i < lc) return {1'b0, 12'(i + 1), 12'd100};
        return {1'b1, 12'(400 + i - lc), 12'd200};
    endfunction

    task automatic chk_run(input string tag, input int lc, input int rc);
        int err;
        chk({tag, "_npts"}, 32'(pts.size()), 32'(lc + rc));
        err = 0;
        foreach (pts[i]) if (pts[i] !== exp_pt(i, lc)) err = err + 1;
        chk({tag, "_pts"}, 32'(err), 32'd0);
        chk({tag, "_nl"}, 32'(laddr.size()), 32'(lc));
        chk({tag, "_nr"}, 32'(raddr.size()), 32'(rc));
        err = 0;
        foreach (laddr[i]) if (laddr[i] != i) err = err + 1;
        foreach (raddr[i]) if (raddr[i] != i) err = err + 1;
        chk({tag, "_addr"}, 32'(err), 32'd0);
        chk({tag, "_fd"}, 32'(fd_cnt), 32'd1);
        chk({tag, "_viol"}, 32'(viol), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_done = 1'b0;
        left_cnt   = '0;
        right_cnt  = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_vld",   32'(bus.pt_vld), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_lrden", 32'(bus.left_rden), 32'd0);
        chk("rst_rrden", 32'(bus.right_rden), 32'd0);
        chk("rst_fd",    32'(fetch_done), 32'd0);
        chk("rst_drop",  32'(frame_drop), 32'd0);
        @(posedge clk);
        #1;

        // Basic fetch, pt_rdy held high
        clear_mon();
        frame(3, 2);
        wait_idle("basic_to", 200);
        chk_run("basic", 3, 2);
        if (pts.size() == 5) begin
            chk("basic_p0", 32'(pts[0]), 32'({1'b0, 12'd1, 12'd100}));
            chk("basic_p4", 32'(pts[4]), 32'({1'b1, 12'd401, 12'd200}));
            chk("basic_lat", 32'(acc_cyc[0] - f_cyc), 32'd3);
            chk("basic_span", 32'(acc_cyc[4] - acc_cyc[0]), 32'd4);
            chk("basic_fd_after", 32'(fd_cyc > acc_cyc[4]), 32'd1);
        end

        // Backpressure
        clear_mon();
        rdy_mode = 1'b1;
        frame(3, 2);
        wait_idle("bp_to", 300);
        chk_run("bp", 3, 2);
        rdy_mode = 1'b0;

        // Empty frame
        clear_mon();
        frame(0, 0);
        wait_idle("empty_to", 50);
        chk("empty_fdcyc", 32'(fd_cyc - f_cyc), 32'd2);
        chk_run("empty", 0, 0);

        // One-sided frames
        clear_mon();
        frame(0, 4);
        wait_idle("r4_to", 200);
        chk_run("r4", 0, 4);
        clear_mon();
        frame(4, 0);
        wait_idle("l4_to", 200);
        chk_run("l4", 4, 0);

        // Saturation
        clear_mon();
        frame(300, 256);
        wait_idle("sat_to", 2000);
        chk_run("sat", 256, 256);

        // Overrun: second frame_done while in LEFT
        clear_mon();
        frame(3, 2);
        @(posedge clk);
        #1;
        left_cnt   = 9'd1;
        right_cnt  = 9'd1;
        frame_done = 1'b1;
        d_cyc      = cyc;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
        wait_idle("ovr_to", 200);
        chk("ovr_drops", 32'(drop_cnt), 32'd1);
        chk("ovr_dropcyc", 32'(drop_cyc - d_cyc), 32'd1);
        chk_run("ovr", 3, 2);

        // Reset while in RIGHT with the FIFO full
        clear_mon();
        rdy_const = 1'b0;
        frame(0, 3);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_vld",  32'(bus.pt_vld), 32'd1);
        chk("pre_rst_side", 32'(bus.pt_side), 32'd1);
        chk("pre_rst_x",    32'(bus.pt_x), 32'd400);
        chk("pre_rst_nr",   32'(raddr.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld",   32'(bus.pt_vld), 32'd0);
        chk("mid_rst_x",     32'(bus.pt_x), 32'd0);
        chk("mid_rst_y",     32'(bus.pt_y), 32'd0);
        chk("mid_rst_side",  32'(bus.pt_side), 32'd0);
        chk("mid_rst_rrden", 32'(bus.right_rden), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rdy_const = 1'b1;
        clear_mon();
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_nofd", 32'(fd_cnt), 32'd0);
        frame(3, 2);
        wait_idle("post_to", 200);
        chk_run("post", 3, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
